// File: rtl/memory_store_unit.sv
// memory_store_unit
//
// Store-side data path between the execute/memory stage and the data-memory
// write port. A store request (sb/sh/sw) is turned into one or two word-aligned
// memory writes with lane-positioned data and byte enables. A store that
// spills past a 32-bit word boundary becomes a low write followed by a high
// write to the next word. With SPLIT_MISALIGNED = 0, such stores are rejected
// instead.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   store_valid/ready       request handshake from the core
//   store_address           byte address of the store
//   store_data              rs2 value; low byte/half used for sb/sh
//   funct3                  000 sb, 001 sh, 010 sw, others illegal
//   mem_write_req/ack       write handshake to data memory
//   mem_write_address       word-aligned write address
//   mem_write_data          lane-positioned write data (disabled lanes 0)
//   mem_write_byte_enable   per-lane byte enables
//   store_done              one-cycle pulse, store completed
//   store_error             one-cycle pulse, request rejected

module memory_store_unit #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        store_valid,
  output logic        store_ready,
  input  logic [31:0] store_address,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  output logic        mem_write_req,
  input  logic        mem_write_ack,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_byte_enable,
  output logic        store_done,
  output logic        store_error
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE_LO,
    WRITE_HI
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  be_q, be_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic [31:0] hi_addr_q, hi_addr_d;
  logic [31:0] hi_data_q, hi_data_d;
  logic [3:0]  hi_be_q, hi_be_d;
  logic        cross_q, cross_d;

  // Request decode straight from the inputs; only used on the accept cycle.
  logic [1:0]  lane;
  logic [2:0]  size_bytes;
  logic [3:0]  size_mask;
  logic [31:0] masked_data;
  logic        legal;
  logic        crossing;
  logic [7:0]  be_wide;
  logic [63:0] data_wide;
  logic [31:0] lo_addr;
  logic [31:0] hi_addr;

  assign lane = store_address[1:0];

  always_comb begin
    size_bytes  = 3'd0;
    size_mask   = 4'b0000;
    masked_data = 32'd0;
    legal       = 1'b1;
    case (funct3)
      3'b000: begin
        size_bytes  = 3'd1;
        size_mask   = 4'b0001;
        masked_data = {24'd0, store_data[7:0]};
      end
      3'b001: begin
        size_bytes  = 3'd2;
        size_mask   = 4'b0011;
        masked_data = {16'd0, store_data[15:0]};
      end
      3'b010: begin
        size_bytes  = 3'd4;
        size_mask   = 4'b1111;
        masked_data = store_data;
      end
      default: legal = 1'b0;
    endcase
  end

  // Shifting into a double-width vector gives both halves at once: the low
  // half is the first-word lane image, the high half is what spills into the
  // next word (equivalent to shifting right by 4 - lane).
  assign crossing  = ({1'b0, lane} + size_bytes) > 3'd4;
  assign be_wide   = {4'b0000, size_mask} << lane;
  assign data_wide = {32'd0, masked_data} << {lane, 3'b000};
  assign lo_addr   = {store_address[31:2], 2'b00};
  assign hi_addr   = lo_addr + 32'd4;

  assign store_ready           = (state_q == IDLE);
  assign mem_write_req         = req_q;
  assign mem_write_address     = addr_q;
  assign mem_write_data        = data_q;
  assign mem_write_byte_enable = be_q;
  assign store_done            = done_q;
  assign store_error           = error_q;

  // State and registered outputs. Reset clears the request immediately, so a
  // store caught mid-flight is abandoned without any done/error pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      be_q      <= 4'd0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      hi_addr_q <= 32'd0;
      hi_data_q <= 32'd0;
      hi_be_q   <= 4'd0;
      cross_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      be_q      <= be_d;
      done_q    <= done_d;
      error_q   <= error_d;
      hi_addr_q <= hi_addr_d;
      hi_data_q <= hi_data_d;
      hi_be_q   <= hi_be_d;
      cross_q   <= cross_d;
    end
  end

  // Next-state logic. Write outputs are loaded when a write state is entered
  // and otherwise held, which keeps them stable while waiting for ack.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    data_d    = data_q;
    be_d      = be_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    hi_addr_d = hi_addr_q;
    hi_data_d = hi_data_q;
    hi_be_d   = hi_be_q;
    cross_d   = cross_q;

    case (state_q)
      IDLE: begin
        if (store_valid) begin
          if (!legal || (crossing && !SPLIT_MISALIGNED)) begin
            error_d = 1'b1;
          end else begin
            state_d   = WRITE_LO;
            req_d     = 1'b1;
            addr_d    = lo_addr;
            data_d    = data_wide[31:0];
            be_d      = be_wide[3:0];
            hi_addr_d = hi_addr;
            hi_data_d = data_wide[63:32];
            hi_be_d   = be_wide[7:4];
            cross_d   = crossing;
          end
        end
      end

      WRITE_LO: begin
        if (mem_write_ack) begin
          if (cross_q) begin
            state_d = WRITE_HI;
            addr_d  = hi_addr_q;
            data_d  = hi_data_q;
            be_d    = hi_be_q;
          end else begin
            state_d = IDLE;
            req_d   = 1'b0;
            addr_d  = 32'd0;
            data_d  = 32'd0;
            be_d    = 4'd0;
            done_d  = 1'b1;
          end
        end
      end

      WRITE_HI: begin
        if (mem_write_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          addr_d  = 32'd0;
          data_d  = 32'd0;
          be_d    = 4'd0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        addr_d  = 32'd0;
        data_d  = 32'd0;
        be_d    = 4'd0;
      end
    endcase
  end

endmodule
